// File: rtl/detect_count_display.sv
// Display stage for the 1100 detector: BCD match count, input history,
// and an eight-digit common-anode multiplexed 7-segment scan.
module detect_count_display #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Step,
    input  logic       Bit_in,
    input  logic       Match,
    input  logic       Clear,
    output logic [7:0] Indicators,
    output logic [7:0] Segments
);

    localparam int RW = $clog2(SCAN_DIV);
    localparam logic [RW-1:0] REF_MAX = RW'(SCAN_DIV - 1);

    logic [3:0][3:0] cnt_q, cnt_d;
    logic [3:0]      hist_q, hist_d;
    logic            ovf_q, ovf_d;
    logic            mflag_q, mflag_d;
    logic [RW-1:0]   refresh_q, refresh_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      ind_q, ind_d;
    logic [7:0]      seg_q, seg_d;

    logic            carry;
    logic [3:0]      nib;
    logic            blank;
    logic            dp;
    logic [6:0]      seg7;

    // Sample step: shift history, latch match, ripple-carry BCD increment
    always_comb begin
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        ovf_d   = ovf_q;
        mflag_d = mflag_q;
        carry   = 1'b0;
        if (Clear) begin
            cnt_d   = '0;
            hist_d  = '0;
            ovf_d   = 1'b0;
            mflag_d = 1'b0;
        end else if (Step) begin
            hist_d  = {hist_q[2:0], Bit_in};
            mflag_d = Match;
            carry   = Match;
            for (int k = 0; k < 4; k++) begin
                if (carry) begin
                    if (cnt_q[k] == 4'd9) begin
                        cnt_d[k] = 4'd0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
            if (carry) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Scan timer: dwell SCAN_DIV cycles per digit, then advance the digit
    always_comb begin
        refresh_d = refresh_q + RW'(1);
        idx_d     = idx_q;
        if (refresh_q == REF_MAX) begin
            refresh_d = '0;
            idx_d     = idx_q + 3'd1;
        end
    end

    // Pick the value, blanking and decimal point for the selected digit
    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        unique case (idx_q)
            3'd0: nib = cnt_q[0];
            3'd1: begin
                nib   = cnt_q[1];
                blank = (cnt_q[3:1] == 12'd0);
            end
            3'd2: begin
                nib   = cnt_q[2];
                blank = (cnt_q[3:2] == 8'd0);
            end
            3'd3: begin
                nib   = cnt_q[3];
                blank = (cnt_q[3] == 4'd0);
            end
            default: nib = {3'b000, hist_q[idx_q[1:0]]};
        endcase
        dp = ((idx_q == 3'd0) && mflag_q) || ((idx_q == 3'd7) && ovf_q);
    end

    // Active-low g..a decode of one decimal digit
    always_comb begin
        unique case (nib)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
        ind_d = ~(8'b1 << idx_q);
        seg_d = {~dp, blank ? 7'h7F : seg7};
    end

    // State and registered pin drivers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            hist_q    <= '0;
            ovf_q     <= 1'b0;
            mflag_q   <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
            ind_q     <= 8'hFF;
            seg_q     <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            hist_q    <= hist_d;
            ovf_q     <= ovf_d;
            mflag_q   <= mflag_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            ind_q     <= ind_d;
            seg_q     <= seg_d;
        end
    end

    assign Indicators = ind_q;
    assign Segments   = seg_q;

endmodule
